// File: rtl/cmos_pkg.sv
// Shared definitions for the CMOS capture front-end: FSM states, coordinate width
// and default sensor geometry.
package cmos_pkg;
    localparam int COORD_W   = 12;
    localparam int DEF_H_ACT = 640;
    localparam int DEF_V_ACT = 480;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SKIP,
        ST_WAIT_SOF,
        ST_ACTIVE
    } cap_state_t;
endpackage

// File: rtl/cmos_byte_packer.sv
// Assembles BPP sensor bytes (first byte into the MSBs) into one pixel and flags
// line ends, reporting whether a partial pixel was pending when HREF dropped.
module cmos_byte_packer #(
    parameter int DATA_W = 8,
    parameter int BPP    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     href,
    input  logic [DATA_W-1:0]        data,
    output logic [DATA_W*BPP-1:0]    pix,
    output logic                     vld,
    output logic                     line_end,
    output logic                     partial
);
    localparam int PW = DATA_W * BPP;

    logic [1:0]    cnt;
    logic [PW-1:0] acc;
    logic [PW-1:0] acc_next;
    logic          href_d;

    assign acc_next = (acc << DATA_W) | PW'(data);

    // p0 -> p1: byte assembly and line-end detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc      <= '0;
            pix      <= '0;
            vld      <= 1'b0;
            line_end <= 1'b0;
            partial  <= 1'b0;
            href_d   <= 1'b0;
        end else begin
            href_d   <= href;
            vld      <= 1'b0;
            line_end <= href_d && !href;
            partial  <= href_d && !href && (cnt != 2'd0);
            if (href) begin
                acc <= acc_next;
                if (cnt == 2'(BPP - 1)) begin
                    cnt <= 2'd0;
                    pix <= acc_next;
                    vld <= 1'b1;
                end else begin
                    cnt <= cnt + 2'd1;
                end
            end else begin
                cnt <= 2'd0;
            end
        end
    end
endmodule

// File: rtl/cmos_capture_win.sv
// DVP sensor capture with frame skipping after configuration, runtime crop window,
// SOF/EOL/EOF markers and per-frame geometry error flags.
module cmos_capture_win
    import cmos_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int BPP         = 2,
    parameter int H_ACT       = DEF_H_ACT,
    parameter int V_ACT       = DEF_V_ACT,
    parameter int SKIP_FRAMES = 10,
    parameter int VS_ACT_LOW  = 1
) (
    input  logic                   iCLK,
    input  logic                   iRST_N,
    input  logic                   Config_Done,
    input  logic                   CMOS_VSYNC,
    input  logic                   CMOS_HREF,
    input  logic [DATA_W-1:0]      CMOS_iDATA,
    input  logic [11:0]            iX_START,
    input  logic [11:0]            iX_END,
    input  logic [11:0]            iY_START,
    input  logic [11:0]            iY_END,
    output logic [DATA_W*BPP-1:0]  oPIX_DATA,
    output logic                   oPIX_VALID,
    output logic                   oSOF,
    output logic                   oEOL,
    output logic                   oEOF,
    output logic [15:0]            oFRAME_CNT,
    output logic                   oERR_LINE,
    output logic                   oERR_FRAME
);
    function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
        return (&v) ? v : v + COORD_W'(1);
    endfunction

    logic                    vs_p0, href_p0;
    logic [DATA_W-1:0]       data_p0;
    logic [DATA_W*BPP-1:0]   pix_p1;
    logic                    vld_p1, line_end_p1, partial_p1;

    cap_state_t              state;
    logic [15:0]             skip_cnt;
    logic [COORD_W-1:0]      x, y, xs, xe, ys, ye;
    logic                    line_err, sof_pend, vs_act_d;
    logic                    vs_act, sof_edge, eof_edge, in_win;

    // pins -> p0: single input register
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            vs_p0   <= (VS_ACT_LOW != 0);
            href_p0 <= 1'b0;
            data_p0 <= '0;
        end else begin
            vs_p0   <= CMOS_VSYNC;
            href_p0 <= CMOS_HREF;
            data_p0 <= CMOS_iDATA;
        end
    end

    cmos_byte_packer #(.DATA_W(DATA_W), .BPP(BPP)) u_packer (
        .clk      (iCLK),
        .rst_n    (iRST_N),
        .href     (href_p0),
        .data     (data_p0),
        .pix      (pix_p1),
        .vld      (vld_p1),
        .line_end (line_end_p1),
        .partial  (partial_p1)
    );

    assign vs_act   = (VS_ACT_LOW != 0) ? !vs_p0 : vs_p0;
    assign sof_edge = vs_act && !vs_act_d;
    assign eof_edge = !vs_act && vs_act_d;
    assign in_win   = (x >= xs) && (x <= xe) && (y >= ys) && (y <= ye);

    // p1 -> p2: control FSM, window compare and registered outputs
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= ST_IDLE;
            skip_cnt   <= '0;
            x          <= '0;
            y          <= '0;
            xs         <= '0;
            xe         <= '0;
            ys         <= '0;
            ye         <= '0;
            line_err   <= 1'b0;
            sof_pend   <= 1'b0;
            vs_act_d   <= 1'b0;
            oPIX_DATA  <= '0;
            oPIX_VALID <= 1'b0;
            oSOF       <= 1'b0;
            oEOL       <= 1'b0;
            oEOF       <= 1'b0;
            oFRAME_CNT <= '0;
            oERR_LINE  <= 1'b0;
            oERR_FRAME <= 1'b0;
        end else begin
            vs_act_d   <= vs_act;
            oPIX_VALID <= 1'b0;
            oSOF       <= 1'b0;
            oEOL       <= 1'b0;
            oEOF       <= 1'b0;
            if (!Config_Done) begin
                state      <= ST_IDLE;
                skip_cnt   <= '0;
                oPIX_DATA  <= '0;
                oFRAME_CNT <= '0;
                oERR_LINE  <= 1'b0;
                oERR_FRAME <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: state <= (SKIP_FRAMES == 0) ? ST_WAIT_SOF : ST_SKIP;
                    ST_SKIP: begin
                        if (eof_edge) begin
                            skip_cnt <= skip_cnt + 16'd1;
                            if (skip_cnt == 16'(SKIP_FRAMES - 1))
                                state <= ST_WAIT_SOF;
                        end
                    end
                    ST_WAIT_SOF: begin
                        // window is frozen here so mid-frame edits only affect the next frame
                        if (sof_edge) begin
                            state    <= ST_ACTIVE;
                            xs       <= iX_START;
                            xe       <= iX_END;
                            ys       <= iY_START;
                            ye       <= iY_END;
                            x        <= '0;
                            y        <= '0;
                            line_err <= 1'b0;
                            sof_pend <= 1'b1;
                        end
                    end
                    ST_ACTIVE: begin
                        if (eof_edge) begin
                            state      <= ST_WAIT_SOF;
                            oEOF       <= 1'b1;
                            oFRAME_CNT <= oFRAME_CNT + 16'd1;
                            oERR_LINE  <= line_err;
                            oERR_FRAME <= (y != COORD_W'(V_ACT));
                        end else if (line_end_p1) begin
                            if ((x != COORD_W'(H_ACT)) || partial_p1)
                                line_err <= 1'b1;
                            y <= sat_inc(y);
                            x <= '0;
                        end else if (vld_p1) begin
                            if (in_win) begin
                                oPIX_DATA  <= pix_p1;
                                oPIX_VALID <= 1'b1;
                                oSOF       <= sof_pend;
                                oEOL       <= (x == xe);
                                sof_pend   <= 1'b0;
                            end
                            x <= sat_inc(x);
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cmos_capture_win.sv
// Self-checking bench for cmos_capture_win using a reduced sensor geometry and a
// pixel-list reference model built from window rules.
module tb_cmos_capture_win;
    localparam int H  = 24;
    localparam int V  = 8;
    localparam int SK = 3;

    logic        clk = 1'b0;
    logic        rst_n, cfg, vsync, href;
    logic [7:0]  din;
    logic [11:0] xs, xe, ys, ye;
    logic [15:0] pix, fcnt;
    logic        vld, sof, eol, eof, el, ef;

    always #5 clk = ~clk;

    cmos_capture_win #(
        .DATA_W(8), .BPP(2), .H_ACT(H), .V_ACT(V), .SKIP_FRAMES(SK), .VS_ACT_LOW(1)
    ) dut (
        .iCLK(clk), .iRST_N(rst_n), .Config_Done(cfg),
        .CMOS_VSYNC(vsync), .CMOS_HREF(href), .CMOS_iDATA(din),
        .iX_START(xs), .iX_END(xe), .iY_START(ys), .iY_END(ye),
        .oPIX_DATA(pix), .oPIX_VALID(vld), .oSOF(sof), .oEOL(eol), .oEOF(eof),
        .oFRAME_CNT(fcnt), .oERR_LINE(el), .oERR_FRAME(ef)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // monitor: every strobe recorded as {data, sof, eol}
    logic [17:0] got_q[$];
    logic [17:0] exp_q[$];
    int          eof_cnt = 0;
    int          stray   = 0;
    logic        eof_el, eof_ef;

    always @(negedge clk) begin
        if (vld) got_q.push_back({pix, sof, eol});
        else if (sof || eol) stray++;
        if (eof) begin
            eof_cnt++;
            eof_el = el;
            eof_ef = ef;
        end
    end

    // reference model state: window latched at frame start
    int lx0, lx1, ly0, ly1;
    bit first;
    bit mid_chg = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_line(input int npix, input int y, input bit cap);
        logic [7:0] b0, b1;
        href = 1'b1;
        for (int x = 0; x < npix; x++) begin
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            din = b0; tick();
            din = b1; tick();
            if (cap && x >= lx0 && x <= lx1 && y >= ly0 && y <= ly1) begin
                exp_q.push_back({b0, b1, first, 1'(x == lx1)});
                first = 0;
            end
        end
        href = 1'b0;
        din  = 8'h00;
        repeat (6) tick();
    endtask

    task automatic start_frame();
        lx0 = int'(xs); lx1 = int'(xe); ly0 = int'(ys); ly1 = int'(ye);
        first = 1;
        vsync = 1'b0;
        repeat (4) tick();
    endtask

    task automatic drive_frame(input int nlines, input int short_y, input int short_len, input bit cap);
        start_frame();
        if (mid_chg) begin
            xs = 12'd0; xe = 12'(H - 1); ys = 12'd0; ye = 12'(V - 1);
            mid_chg = 0;
        end
        for (int y = 0; y < nlines; y++)
            drive_line((y == short_y) ? short_len : H, y, cap);
        vsync = 1'b1;
        repeat (8) tick();
    endtask

    task automatic full_window();
        xs = 12'd0; xe = 12'(H - 1); ys = 12'd0; ye = 12'(V - 1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg = 1'b0; vsync = 1'b1; href = 1'b0; din = 8'h00;
        full_window();
        repeat (3) tick();
        n_checks++; if (vld !== 1'b0)    begin n_fail++; $display("FAIL reset_valid got %b want 0", vld); end
        n_checks++; if (sof !== 1'b0)    begin n_fail++; $display("FAIL reset_sof got %b want 0", sof); end
        n_checks++; if (eol !== 1'b0)    begin n_fail++; $display("FAIL reset_eol got %b want 0", eol); end
        n_checks++; if (eof !== 1'b0)    begin n_fail++; $display("FAIL reset_eof got %b want 0", eof); end
        n_checks++; if (pix !== 16'h0)   begin n_fail++; $display("FAIL reset_data got %h want 0", pix); end
        n_checks++; if (fcnt !== 16'h0)  begin n_fail++; $display("FAIL reset_fcnt got %0d want 0", fcnt); end
        n_checks++; if ({el, ef} !== 2'b00) begin n_fail++; $display("FAIL reset_err got %b want 00", {el, ef}); end
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_skip();
        int g0, e0, q0;
        cfg = 1'b1;
        tick();
        g0 = got_q.size(); q0 = eof_cnt;
        for (int f = 0; f < SK; f++) drive_frame(V, -1, 0, 0);
        n_checks++; if (got_q.size() != g0) begin n_fail++; $display("FAIL skip_strobes got %0d want 0", got_q.size() - g0); end
        n_checks++; if (eof_cnt != q0)      begin n_fail++; $display("FAIL skip_eof got %0d want 0", eof_cnt - q0); end
        g0 = got_q.size(); e0 = exp_q.size();
        drive_frame(V, -1, 0, 1);
        n_checks++;
        if (got_q.size() - g0 != H * V) begin n_fail++; $display("FAIL skip_count got %0d want %0d", got_q.size() - g0, H * V); end
        for (int i = 0; i < exp_q.size() - e0 && g0 + i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[g0 + i] !== exp_q[e0 + i]) begin n_fail++; $display("FAIL skip_pix[%0d] got %h want %h", i, got_q[g0 + i], exp_q[e0 + i]); end
        end
        n_checks++; if (fcnt !== 16'd1)   begin n_fail++; $display("FAIL skip_fcnt got %0d want 1", fcnt); end
        n_checks++; if (eof_cnt != q0 + 1) begin n_fail++; $display("FAIL skip_eofcnt got %0d want 1", eof_cnt - q0); end
        n_checks++; if ({eof_el, eof_ef} !== 2'b00) begin n_fail++; $display("FAIL skip_err got %b want 00", {eof_el, eof_ef}); end
    endtask

    task automatic test_packing();
        full_window();
        start_frame();
        href = 1'b1;
        din = 8'hF8; tick();
        din = 8'h1F; tick();
        href = 1'b0; din = 8'h00;
        tick();
        n_checks++; if (vld !== 1'b0) begin n_fail++; $display("FAIL pack_early got %b want 0", vld); end
        tick();
        n_checks++; if (vld !== 1'b1) begin n_fail++; $display("FAIL pack_valid got %b want 1", vld); end
        n_checks++; if (pix !== 16'hF81F) begin n_fail++; $display("FAIL pack_data got %h want f81f", pix); end
        n_checks++; if (sof !== 1'b1) begin n_fail++; $display("FAIL pack_sof got %b want 1", sof); end
        repeat (6) tick();
        vsync = 1'b1;
        repeat (8) tick();
        n_checks++; if ({eof_el, eof_ef} !== 2'b11) begin n_fail++; $display("FAIL pack_err got %b want 11", {eof_el, eof_ef}); end
        n_checks++; if (fcnt !== 16'd2) begin n_fail++; $display("FAIL pack_fcnt got %0d want 2", fcnt); end
    endtask

    task automatic test_crop();
        int g0, e0;
        xs = 12'd10; xe = 12'd19; ys = 12'd5; ye = 12'd6;
        mid_chg = 1;
        g0 = got_q.size(); e0 = exp_q.size();
        drive_frame(V, -1, 0, 1);
        n_checks++;
        if (got_q.size() - g0 != 20) begin n_fail++; $display("FAIL crop_count got %0d want 20", got_q.size() - g0); end
        for (int i = 0; i < exp_q.size() - e0 && g0 + i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[g0 + i] !== exp_q[e0 + i]) begin n_fail++; $display("FAIL crop_pix[%0d] got %h want %h", i, got_q[g0 + i], exp_q[e0 + i]); end
        end
        n_checks++; if ({eof_el, eof_ef} !== 2'b00) begin n_fail++; $display("FAIL crop_err got %b want 00", {eof_el, eof_ef}); end
    endtask

    task automatic test_geometry();
        int g0, e0;
        full_window();
        g0 = got_q.size(); e0 = exp_q.size();
        drive_frame(V - 1, 3, H - 1, 1);
        n_checks++;
        if (got_q.size() - g0 != exp_q.size() - e0) begin n_fail++; $display("FAIL geom_count got %0d want %0d", got_q.size() - g0, exp_q.size() - e0); end
        for (int i = 0; i < exp_q.size() - e0 && g0 + i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[g0 + i] !== exp_q[e0 + i]) begin n_fail++; $display("FAIL geom_pix[%0d] got %h want %h", i, got_q[g0 + i], exp_q[e0 + i]); end
        end
        n_checks++; if ({eof_el, eof_ef} !== 2'b11) begin n_fail++; $display("FAIL geom_err got %b want 11", {eof_el, eof_ef}); end
        n_checks++; if ({el, ef} !== 2'b11) begin n_fail++; $display("FAIL geom_hold got %b want 11", {el, ef}); end
        drive_frame(V, -1, 0, 1);
        n_checks++; if ({eof_el, eof_ef} !== 2'b00) begin n_fail++; $display("FAIL geom_clear got %b want 00", {eof_el, eof_ef}); end
    endtask

    task automatic test_empty();
        int g0, q0;
        logic [15:0] f0;
        xs = 12'd20; xe = 12'd10; ys = 12'd0; ye = 12'(V - 1);
        g0 = got_q.size(); q0 = eof_cnt; f0 = fcnt;
        drive_frame(V, -1, 0, 1);
        n_checks++; if (got_q.size() != g0) begin n_fail++; $display("FAIL empty_strobes got %0d want 0", got_q.size() - g0); end
        n_checks++; if (eof_cnt != q0 + 1)  begin n_fail++; $display("FAIL empty_eof got %0d want 1", eof_cnt - q0); end
        n_checks++; if (fcnt !== f0 + 16'd1) begin n_fail++; $display("FAIL empty_fcnt got %0d want %0d", fcnt, f0 + 16'd1); end
    endtask

    task automatic test_random_windows();
        int g0, e0;
        for (int k = 0; k < 3; k++) begin
            xs = 12'($urandom_range(0, H + 1)); xe = 12'($urandom_range(0, H + 1));
            ys = 12'($urandom_range(0, V + 1)); ye = 12'($urandom_range(0, V + 1));
            g0 = got_q.size(); e0 = exp_q.size();
            drive_frame(V, -1, 0, 1);
            n_checks++;
            if (got_q.size() - g0 != exp_q.size() - e0) begin n_fail++; $display("FAIL rand%0d_count got %0d want %0d", k, got_q.size() - g0, exp_q.size() - e0); end
            for (int i = 0; i < exp_q.size() - e0 && g0 + i < got_q.size(); i++) begin
                n_checks++;
                if (got_q[g0 + i] !== exp_q[e0 + i]) begin n_fail++; $display("FAIL rand%0d_pix[%0d] got %h want %h", k, i, got_q[g0 + i], exp_q[e0 + i]); end
            end
        end
    endtask

    task automatic test_abort();
        int g0, e0, q0, gd;
        full_window();
        g0 = got_q.size(); e0 = exp_q.size(); q0 = eof_cnt;
        start_frame();
        drive_line(H, 0, 1);
        drive_line(H, 1, 1);
        cfg = 1'b0;
        tick();
        gd = got_q.size();
        for (int y = 2; y < V; y++) drive_line(H, y, 0);
        vsync = 1'b1;
        repeat (8) tick();
        n_checks++; if (gd - g0 != 2 * H) begin n_fail++; $display("FAIL abort_before got %0d want %0d", gd - g0, 2 * H); end
        for (int i = 0; i < exp_q.size() - e0 && g0 + i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[g0 + i] !== exp_q[e0 + i]) begin n_fail++; $display("FAIL abort_pix[%0d] got %h want %h", i, got_q[g0 + i], exp_q[e0 + i]); end
        end
        n_checks++; if (got_q.size() != gd) begin n_fail++; $display("FAIL abort_after got %0d want 0", got_q.size() - gd); end
        n_checks++; if (eof_cnt != q0)      begin n_fail++; $display("FAIL abort_eof got %0d want 0", eof_cnt - q0); end
        n_checks++; if (fcnt !== 16'd0)     begin n_fail++; $display("FAIL abort_fcnt got %0d want 0", fcnt); end
        cfg = 1'b1;
        tick();
        g0 = got_q.size(); q0 = eof_cnt;
        for (int f = 0; f < SK; f++) drive_frame(V, -1, 0, 0);
        n_checks++; if (got_q.size() != g0) begin n_fail++; $display("FAIL reskip_strobes got %0d want 0", got_q.size() - g0); end
        n_checks++; if (eof_cnt != q0)      begin n_fail++; $display("FAIL reskip_eof got %0d want 0", eof_cnt - q0); end
        g0 = got_q.size(); e0 = exp_q.size();
        drive_frame(V, -1, 0, 1);
        n_checks++;
        if (got_q.size() - g0 != H * V) begin n_fail++; $display("FAIL recap_count got %0d want %0d", got_q.size() - g0, H * V); end
        for (int i = 0; i < exp_q.size() - e0 && g0 + i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[g0 + i] !== exp_q[e0 + i]) begin n_fail++; $display("FAIL recap_pix[%0d] got %h want %h", i, got_q[g0 + i], exp_q[e0 + i]); end
        end
        n_checks++; if (fcnt !== 16'd1) begin n_fail++; $display("FAIL recap_fcnt got %0d want 1", fcnt); end
    endtask

    initial begin
        test_reset();
        test_skip();
        test_packing();
        test_crop();
        test_geometry();
        test_empty();
        test_random_windows();
        test_abort();
        n_checks++;
        if (stray != 0) begin n_fail++; $display("FAIL stray_markers got %0d want 0", stray); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
